// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_DATA_W  = 32;

  // Index of the set bit; only meaningful for a one-hot argument.
  function automatic int onehot_to_idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or after ptr+1, with wrap.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          any_req
);

  logic found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a one-hot mux select and steering the owner's data word.
// Optional forced handover after MAX_HOLD grant cycles: define MUX_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant held, waiting for any req
// BUSY  | one requester owns the mux until it drops req (or its hold expires)
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
`ifdef MUX_ARB_TIMEOUT_EN
  , parameter int MAX_HOLD = 8
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        sel,
  output logic [DATA_W-1:0]         mux_out,
  output logic                      out_valid
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state, state_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] win;
  logic               any_req;
  logic [PW-1:0]      ptr, ptr_n, win_idx;
  logic               owner_req;
  logic               hold_expired;

  // Masking the owner means a release-cycle re-raise never wins over a pending peer.
  assign pick_req  = (state == IDLE) ? req : (req & ~grant);
  assign owner_req = |(req & grant);
  assign win_idx   = PW'(onehot_to_idx(32'(win)));

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_pick (
    .req     (pick_req),
    .ptr     (ptr),
    .winner  (win),
    .any_req (any_req)
  );

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  logic [HW-1:0] hold_cnt;
  logic          new_grant;

  assign hold_expired = (hold_cnt == HW'(MAX_HOLD - 1));
  assign new_grant    = (state_n == BUSY) && (grant_n != grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (new_grant) begin
      hold_cnt <= '0;
    end else if (state == BUSY && !hold_expired) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_n = win;
          ptr_n   = win_idx;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (!owner_req || hold_expired) begin
          if (any_req) begin
            grant_n = win;
            ptr_n   = win_idx;
          end else if (!owner_req) begin
            grant_n = '0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= PW'(NUM_REQ - 1);
    end else begin
      state <= state_n;
      grant <= grant_n;
      ptr   <= ptr_n;
    end
  end

  assign sel       = grant;
  assign out_valid = $onehot(grant);

  always_comb begin
    mux_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) mux_out = data_in[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed literal checks plus randomized traffic
// against an ownership-level reference model. Honours MUX_ARB_TIMEOUT_EN.
module tb_mux_rr_arbiter;

  localparam int N = 3;
  localparam int W = 32;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam int MAXH = 8;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0]   grant, sel;
  logic [W-1:0]   mux_out;
  logic           out_valid;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  mux_rr_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data_in   (data_in),
    .grant     (grant),
    .sel       (sel),
    .mux_out   (mux_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the mux, where the round-robin search resumes.
  int m_owner = -1;
  int m_ptr   = N - 1;
`ifdef MUX_ARB_TIMEOUT_EN
  int m_cnt   = 0;
`endif

  function automatic int rr_next(input int p, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (p + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int w;
    if (reset) begin
      m_owner <= -1;
      m_ptr   <= N - 1;
`ifdef MUX_ARB_TIMEOUT_EN
      m_cnt   <= 0;
`endif
    end else if (m_owner < 0) begin
      w = rr_next(m_ptr, req);
      if (w >= 0) begin
        m_owner <= w;
        m_ptr   <= w;
`ifdef MUX_ARB_TIMEOUT_EN
        m_cnt   <= 0;
`endif
      end
    end else if (!req[m_owner]) begin
      w = rr_next(m_ptr, req);
      m_owner <= w;
      if (w >= 0) begin
        m_ptr <= w;
`ifdef MUX_ARB_TIMEOUT_EN
        m_cnt <= 0;
`endif
      end
    end
`ifdef MUX_ARB_TIMEOUT_EN
    else if (m_cnt == MAXH - 1 && rr_next(m_ptr, req & ~(3'b001 << m_owner)) >= 0) begin
      w = rr_next(m_ptr, req & ~(3'b001 << m_owner));
      m_owner <= w;
      m_ptr   <= w;
      m_cnt   <= 0;
    end else begin
      m_cnt <= (m_cnt < MAXH - 1) ? m_cnt + 1 : m_cnt;
    end
`endif
  end

  always @(negedge clk) begin : compare
    logic [N-1:0] exp_g;
    logic [W-1:0] exp_d;
    if (cmp_en) begin
      exp_g = (m_owner < 0) ? '0 : N'(1 << m_owner);
      exp_d = (m_owner < 0) ? '0 : data_in[m_owner*W +: W];
      chk("model_grant", 32'(grant), 32'(exp_g));
      chk("model_sel", 32'(sel), 32'(exp_g));
      chk("model_mux_out", mux_out, exp_d);
      chk("model_out_valid", 32'(out_valid), 32'(m_owner >= 0));
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int held;

  initial begin
    data_in = {32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};

    // 1: reset dominates, then requester 0 wins first
    reset = 1'b1; req = 3'b111;
    tick();
    cmp_en = 1'b1;
    tick();
    chk("t1_reset_grant", 32'(grant), 32'h0);
    chk("t1_reset_valid", 32'(out_valid), 32'h0);
    reset = 1'b0;
    tick();
    chk("t1_first_sel", 32'(sel), 32'h1);
    chk("t1_first_data", mux_out, 32'h1111_1111);

    // 2: lone requester, data pass-through, release to idle
    reset = 1'b1; req = 3'b010;
    tick();
    reset = 1'b0;
    tick();
    chk("t2_grant", 32'(grant), 32'h2);
    chk("t2_data", mux_out, 32'hDEAD_BEEF);
    data_in[W +: W] = 32'hCAFE_F00D;
    #1;
    chk("t2_passthru", mux_out, 32'hCAFE_F00D);
    req = 3'b000;
    tick();
    chk("t2_release_grant", 32'(grant), 32'h0);
    chk("t2_release_valid", 32'(out_valid), 32'h0);

    // 3: all requesting, owners release in turn with no bubble
    reset = 1'b1;
    tick();
    reset = 1'b0; req = 3'b111;
    tick();
    chk("t3_g0", 32'(grant), 32'h1);
    tick(); tick();
    req = 3'b110;
    tick();
    chk("t3_g1", 32'(grant), 32'h2);
    req = 3'b111;
    tick(); tick();
    chk("t3_g1_hold", 32'(grant), 32'h2);
    req = 3'b101;
    tick();
    chk("t3_g2", 32'(grant), 32'h4);
    req = 3'b111;
    tick(); tick();
    req = 3'b011;
    tick();
    chk("t3_g0_again", 32'(grant), 32'h1);

    // 4: ptr=0 after owner 0 finished; 101 must go to requester 2
    reset = 1'b1; req = 3'b000;
    tick();
    reset = 1'b0; req = 3'b001;
    tick();
    chk("t4_own0", 32'(grant), 32'h1);
    req = 3'b000;
    tick();
    chk("t4_idle", 32'(grant), 32'h0);
    req = 3'b101;
    tick();
    chk("t4_wrap", 32'(grant), 32'h4);

    // 5: long hold with a peer pending
    reset = 1'b1; req = 3'b000;
    tick();
    reset = 1'b0; req = 3'b001;
    tick();
    held = 1;
    req = 3'b011;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (grant == 3'b001) held++;
      else break;
    end
`ifdef MUX_ARB_TIMEOUT_EN
    chk("t5_hold_len", 32'(held), 32'd8);
    chk("t5_after", 32'(grant), 32'h2);
`else
    chk("t5_hold_len", 32'(held), 32'd21);
    chk("t5_after", 32'(grant), 32'h1);
`endif

    // 6: reset mid-grant, then requester 0 favoured again
    reset = 1'b1; req = 3'b000;
    tick();
    reset = 1'b0; req = 3'b010;
    tick();
    chk("t6_grant", 32'(grant), 32'h2);
    reset = 1'b1;
    tick();
    chk("t6_reset_grant", 32'(grant), 32'h0);
    chk("t6_reset_data", mux_out, 32'h0);
    reset = 1'b0; req = 3'b111;
    tick();
    chk("t6_after_reset", 32'(grant), 32'h1);

    // Random traffic: independent requesters, occasional reset
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, 4) == 0) req[i] = 1'b0;
        end else begin
          if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
        end
      end
      data_in = {$urandom, $urandom, $urandom};
      tick();
    end

    // Sustained all-ones with owners briefly dropping
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      req = 3'b111;
      if ($urandom_range(0, 3) == 0) req = req & ~grant;
      data_in = {$urandom, $urandom, $urandom};
      tick();
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
